vga_timing_tt: RTL and testbench

- Raster timing generator that produces the beam position (sx, sy), sync pulses and data-enable consumed by the sprite renderers and the colour mux.
- It is the source end of the sx/sy pixel-position interface. The renderers are pure functions of sx/sy; this block owns all raster sequencing.
- Runs in the pixel clock domain (25.175 MHz nominal, 640x480@60). All outputs are registered.

---
 rtl/vga_timing_tt_if.sv | 23 ++
 rtl/vga_timing_tt.sv | 91 +++++++++
 tb/tb_vga_timing_tt.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_tt_if.sv
// Pixel-position bus between the raster generator (master) and the
// renderers / colour mux (slave). The slave side owns the advance enable.
interface vga_timing_tt_if;
  logic       en;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    input  en,
    output sx, sy, hsync, vsync, de, line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  sx, sy, hsync, vsync, de, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_tt.sv
// Raster timing generator: beam position, syncs, data enable and
// line/frame strobes. Every output is a flop loaded from the next-state
// counter values, so all outputs describe the sx/sy shown in the same cycle.
module vga_timing_tt #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic            clk_pix,
  input  logic            rst_pix,
  vga_timing_tt_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter bounds must fit the 10-bit position ports.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
    $error("vga_timing_tt: H_TOTAL/V_TOTAL exceed 1024");
  end

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DE_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_DE_END = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       ACT      = (SYNC_POL != 0);

  logic [9:0] sx_q, sy_q, sx_nxt, sy_nxt;
  logic       hs_q, vs_q, de_q, ls_q, fs_q;
  logic [7:0] fc_q;
  logic       wrap_line, wrap_frame;

  // Next raster position; holds when the enable is low.
  always_comb begin
    sx_nxt = sx_q;
    sy_nxt = sy_q;
    if (vga.en) begin
      if (sx_q == H_MAX) begin
        sx_nxt = '0;
        sy_nxt = (sy_q == V_MAX) ? '0 : sy_q + 10'd1;
      end else begin
        sx_nxt = sx_q + 10'd1;
      end
    end
  end

  // Strobes only fire on an enabled edge, so a stall at (0,0) cannot stretch them.
  assign wrap_line  = vga.en && (sx_nxt == '0);
  assign wrap_frame = wrap_line && (sy_nxt == '0);

  // Counters and all decoded outputs, registered from the next-state position.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx_q <= H_MAX;
      sy_q <= V_MAX;
      hs_q <= ~ACT;
      vs_q <= ~ACT;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      fc_q <= '0;
    end else begin
      sx_q <= sx_nxt;
      sy_q <= sy_nxt;
      hs_q <= ((sx_nxt >= HS_BEG) && (sx_nxt < HS_END)) ? ACT : ~ACT;
      vs_q <= ((sy_nxt >= VS_BEG) && (sy_nxt < VS_END)) ? ACT : ~ACT;
      de_q <= (sx_nxt < H_DE_END) && (sy_nxt < V_DE_END);
      ls_q <= wrap_line;
      fs_q <= wrap_frame;
      if (wrap_frame) fc_q <= fc_q + 8'd1;
    end
  end

  assign vga.sx          = sx_q;
  assign vga.sy          = sy_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.de          = de_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_cnt   = fc_q;
endmodule

// File: tb/tb_vga_timing_tt.sv
// Directed bench for vga_timing_tt.
//  u_a : 640x480 timing, active-low syncs
//  u_c : same timing, active-high syncs, same enable as u_a (window compare)
//  u_b : tiny 12x8 raster, used for whole-frame and 256-frame checks
module tb_vga_timing_tt;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  int pol_bad  = 0;

  always #5 clk = ~clk;

  vga_timing_tt_if vif_a ();
  vga_timing_tt_if vif_b ();
  vga_timing_tt_if vif_c ();

  assign vif_c.en = vif_a.en;

  vga_timing_tt u_a (.clk_pix(clk), .rst_pix(rst), .vga(vif_a));

  vga_timing_tt #(.SYNC_POL(1)) u_c (.clk_pix(clk), .rst_pix(rst), .vga(vif_c));

  vga_timing_tt #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .SYNC_POL(0)
  ) u_b (.clk_pix(clk), .rst_pix(rst), .vga(vif_b));

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the edge; also tracks that the
  // active-high instance mirrors the active-low one exactly.
  task automatic step();
    @(posedge clk);
    #1;
    if (vif_c.sx !== vif_a.sx || vif_c.sy !== vif_a.sy ||
        vif_c.de !== vif_a.de ||
        vif_c.hsync !== ~vif_a.hsync || vif_c.vsync !== ~vif_a.vsync)
      pol_bad++;
  endtask

  initial begin
    int n, bad, hcnt, hfirst, hlast, defall;
    int decnt, lscnt, fscnt, vs_sx, vs_sy, vr_sx, vr_sy, nfs, prev;
    logic vprev, wrapped;

    vif_a.en = 1'b0;
    vif_b.en = 1'b0;

    // ---- reset state
    #12;
    chk("rst_sx", vif_a.sx, 799);
    chk("rst_sy", vif_a.sy, 524);
    chk("rst_de", vif_a.de, 0);
    chk("rst_hsync", vif_a.hsync, 1);
    chk("rst_vsync", vif_a.vsync, 1);
    chk("rst_ls", vif_a.line_start, 0);
    chk("rst_fs", vif_a.frame_start, 0);
    chk("rst_fc", vif_a.frame_cnt, 0);
    chk("rst_hsync_pol1", vif_c.hsync, 0);
    chk("rst_vsync_pol1", vif_c.vsync, 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    vif_a.en = 1'b1;

    // ---- first enabled edge
    step();
    chk("first_sx", vif_a.sx, 0);
    chk("first_sy", vif_a.sy, 0);
    chk("first_de", vif_a.de, 1);
    chk("first_ls", vif_a.line_start, 1);
    chk("first_fs", vif_a.frame_start, 1);
    chk("first_fc", vif_a.frame_cnt, 1);
    step();
    chk("second_sx", vif_a.sx, 1);
    chk("second_ls", vif_a.line_start, 0);
    chk("second_fs", vif_a.frame_start, 0);

    // ---- line 0 horizontal windows
    hcnt = 0; hfirst = -1; hlast = -1; defall = -1; n = 0;
    while (vif_a.sx != 0 && n < 900) begin
      if (vif_a.hsync == 1'b0) begin
        hcnt++;
        if (hfirst < 0) hfirst = int'(vif_a.sx);
        hlast = int'(vif_a.sx);
      end
      if (vif_a.de == 1'b0 && defall < 0) defall = int'(vif_a.sx);
      if (vif_a.line_start) bad = 1;
      step();
      n++;
    end
    chk("line0_hs_cnt", hcnt, 96);
    chk("line0_hs_first", hfirst, 656);
    chk("line0_hs_last", hlast, 751);
    chk("line0_de_fall", defall, 640);
    chk("line1_sy", vif_a.sy, 1);
    chk("line1_ls", vif_a.line_start, 1);
    chk("line1_fs", vif_a.frame_start, 0);

    // ---- stall at end of line 10
    n = 0;
    while (!(vif_a.sx == 10'd799 && vif_a.sy == 10'd10) && n < 12000) begin
      step();
      n++;
    end
    chk("reach_799_10", int'(vif_a.sx == 10'd799 && vif_a.sy == 10'd10), 1);
    vif_a.en = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (vif_a.sx != 10'd799 || vif_a.sy != 10'd10 ||
          vif_a.line_start || vif_a.frame_start) bad++;
    end
    chk("stall_hold", bad, 0);
    vif_a.en = 1'b1;
    step();
    chk("resume_sx", vif_a.sx, 0);
    chk("resume_sy", vif_a.sy, 11);
    chk("resume_ls", vif_a.line_start, 1);
    step();
    chk("resume_sx1", vif_a.sx, 1);
    chk("resume_ls_drop", vif_a.line_start, 0);
    chk("active_vsync_idle", vif_a.vsync, 1);

    // ---- asynchronous reset mid-line
    n = 0;
    while (vif_a.sx != 10'd300 && n < 900) begin
      step();
      n++;
    end
    chk("reach_300", vif_a.sx, 300);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sx", vif_a.sx, 799);
    chk("arst_sy", vif_a.sy, 524);
    chk("arst_de", vif_a.de, 0);
    chk("arst_hsync", vif_a.hsync, 1);
    chk("arst_vsync", vif_a.vsync, 1);
    chk("arst_fc", vif_a.frame_cnt, 0);
    chk("arst_hsync_pol1", vif_c.hsync, 0);
    vif_a.en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("pol1_mirror", pol_bad, 0);

    // ---- small raster: one whole frame (12 x 8 = 96 cycles)
    vif_b.en = 1'b1;
    step();
    chk("b_first_sx", vif_b.sx, 0);
    chk("b_first_sy", vif_b.sy, 0);
    chk("b_first_fs", vif_b.frame_start, 1);
    chk("b_first_fc", vif_b.frame_cnt, 1);
    decnt = 0; lscnt = 0; fscnt = 0;
    vs_sx = -1; vs_sy = -1; vr_sx = -1; vr_sy = -1;
    vprev = vif_b.vsync;
    for (int i = 0; i < 96; i++) begin
      if (vif_b.de) decnt++;
      if (vif_b.line_start) lscnt++;
      if (vif_b.frame_start) fscnt++;
      if (vprev && !vif_b.vsync) begin vs_sx = int'(vif_b.sx); vs_sy = int'(vif_b.sy); end
      if (!vprev && vif_b.vsync) begin vr_sx = int'(vif_b.sx); vr_sy = int'(vif_b.sy); end
      vprev = vif_b.vsync;
      step();
    end
    chk("b_de_cnt", decnt, 24);
    chk("b_ls_cnt", lscnt, 8);
    chk("b_fs_cnt", fscnt, 1);
    chk("b_vs_fall_sx", vs_sx, 0);
    chk("b_vs_fall_sy", vs_sy, 5);
    chk("b_vs_rise_sx", vr_sx, 0);
    chk("b_vs_rise_sy", vr_sy, 6);
    chk("b_frame2_pos", int'(vif_b.sx == 10'd0 && vif_b.sy == 10'd0), 1);
    chk("b_frame2_fs", vif_b.frame_start, 1);
    chk("b_frame2_fc", vif_b.frame_cnt, 2);

    // ---- stall at (0,0): frame_start must not re-assert
    vif_b.en = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (vif_b.frame_start || vif_b.line_start ||
          vif_b.sx != 10'd0 || vif_b.sy != 10'd0 || vif_b.frame_cnt != 8'd2) bad++;
    end
    chk("b_stall00", bad, 0);
    vif_b.en = 1'b1;
    step();
    chk("b_after_stall_sx", vif_b.sx, 1);
    chk("b_after_stall_fs", vif_b.frame_start, 0);

    // ---- frame counter wrap 255 -> 0
    nfs = 0; bad = 0; prev = 0; wrapped = 1'b0; n = 0;
    while (!wrapped && n < 30000) begin
      prev = int'(vif_b.frame_cnt);
      step();
      n++;
      if (vif_b.frame_start) begin
        nfs++;
        if (int'(vif_b.frame_cnt) != ((prev + 1) % 256)) bad++;
        if (vif_b.frame_cnt == 8'd0) wrapped = 1'b1;
      end else if (int'(vif_b.frame_cnt) != prev) begin
        bad++;
      end
    end
    chk("b_wrap_seen", int'(wrapped), 1);
    chk("b_wrap_prev", prev, 255);
    chk("b_wrap_fs_cnt", nfs, 254);
    chk("b_fc_steps", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
